// File: rtl/booth_div.sv
// Sequential radix-2 restoring divider on the shared 8-bit command bus.
// Divides operand magnitudes and then applies a sign correction. Quotient is left in Q, remainder in A.
module booth_div #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inbus,
    input  logic [2:0]       enable,
    output logic [WIDTH-1:0] outbus,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_INIT    = 3'b001;
    localparam logic [2:0] OP_LOAD_Q  = 3'b010;
    localparam logic [2:0] OP_LOAD_M  = 3'b011;
    localparam logic [2:0] OP_RUN     = 3'b100;
    localparam logic [2:0] OP_STORE_A = 3'b101;
    localparam logic [2:0] OP_STORE_Q = 3'b110;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ZERO_A = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   ONE_A  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_C = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH:0] neg_a(input logic [WIDTH:0] v);
        return ~v + ONE_A;
    endfunction

    // The most-negative value maps onto itself, which reads correctly as 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic s);
        return s ? neg_w(v) : v;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH:0]   a_r, a_s, a_sh_s, trial_s;
    logic [WIDTH-1:0] q_r, q_s, m_r, m_s, outbus_r, outbus_s;
    logic [CW-1:0]    count_r, count_s;
    logic             sq_r, sq_s, sm_r, sm_s, sq_cap_s, sm_cap_s, fit_s;
    logic             busy_r, busy_s, done_r, done_s, dbz_r, dbz_s, ovf_r, ovf_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (enable == OP_INIT) begin
                    state_s = ST_IDLE;
                end else if (enable == OP_RUN) begin
                    state_s = (m_r == ZERO_W) ? ST_DONE : ST_CALC;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CALC: begin
                if (count_r == LAST_C) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // One restoring step: shift {A,Q} left and try subtracting M
    always_comb begin
        a_sh_s   = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
        trial_s  = a_sh_s - {1'b0, m_r};
        fit_s    = (a_sh_s >= {1'b0, m_r});
        sq_cap_s = SIGNED ? q_r[WIDTH-1] : 1'b0;
        sm_cap_s = SIGNED ? m_r[WIDTH-1] : 1'b0;
    end

    // Datapath and flag next values per state
    always_comb begin
        a_s      = a_r;
        q_s      = q_r;
        m_s      = m_r;
        count_s  = count_r;
        sq_s     = sq_r;
        sm_s     = sm_r;
        outbus_s = outbus_r;
        busy_s   = busy_r;
        done_s   = done_r;
        dbz_s    = dbz_r;
        ovf_s    = ovf_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                case (enable)
                    OP_INIT: begin
                        a_s     = ZERO_A;
                        count_s = ZERO_C;
                        done_s  = 1'b0;
                        dbz_s   = 1'b0;
                        ovf_s   = 1'b0;
                    end
                    OP_LOAD_Q:  q_s = inbus;
                    OP_LOAD_M:  m_s = inbus;
                    OP_STORE_A: outbus_s = a_r[WIDTH-1:0];
                    OP_STORE_Q: outbus_s = q_r;
                    OP_RUN: begin
                        if (m_r == ZERO_W) begin
                            a_s    = {1'b0, q_r};
                            q_s    = ONES_W;
                            dbz_s  = 1'b1;
                            done_s = 1'b1;
                            ovf_s  = 1'b0;
                            busy_s = 1'b0;
                        end else begin
                            sq_s    = sq_cap_s;
                            sm_s    = sm_cap_s;
                            q_s     = mag_w(q_r, sq_cap_s);
                            m_s     = mag_w(m_r, sm_cap_s);
                            a_s     = ZERO_A;
                            count_s = ZERO_C;
                            done_s  = 1'b0;
                            dbz_s   = 1'b0;
                            ovf_s   = 1'b0;
                            busy_s  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_CALC: begin
                a_s     = fit_s ? trial_s : a_sh_s;
                q_s     = {q_r[WIDTH-2:0], fit_s};
                count_s = count_r + ONE_C;
            end
            ST_FIX: begin
                if (SIGNED && (sq_r ^ sm_r)) begin
                    q_s = neg_w(q_r);
                end else begin
                    q_s = q_r;
                end
                // Remainder follows the dividend's sign
                if (SIGNED && sq_r) begin
                    a_s = neg_a(a_r);
                end else begin
                    a_s = a_r;
                end
                ovf_s  = SIGNED && !(sq_r ^ sm_r) && (q_r == MSB_W);
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r      <= ZERO_A;
            q_r      <= ZERO_W;
            m_r      <= ZERO_W;
            count_r  <= ZERO_C;
            sq_r     <= 1'b0;
            sm_r     <= 1'b0;
            outbus_r <= ZERO_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            a_r      <= a_s;
            q_r      <= q_s;
            m_r      <= m_s;
            count_r  <= count_s;
            sq_r     <= sq_s;
            sm_r     <= sm_s;
            outbus_r <= outbus_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            dbz_r    <= dbz_s;
            ovf_r    <= ovf_s;
        end
    end

    assign outbus = outbus_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign dbz    = dbz_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_booth_div.sv
// Bench for booth_div: a signed and an unsigned instance share one command stream and are both
// compared every cycle against an arithmetic reference model, plus literal expectations.
module tb_booth_div;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [W-1:0]     inbus;
    logic [2:0]       enable;
    logic [1:0][W-1:0] ob;
    logic [1:0]       bz, dn, dz, ov;

    booth_div #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .inbus(inbus), .enable(enable),
        .outbus(ob[0]), .busy(bz[0]), .done(dn[0]), .dbz(dz[0]), .ovf(ov[0])
    );
    booth_div #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .inbus(inbus), .enable(enable),
        .outbus(ob[1]), .busy(bz[1]), .done(dn[1]), .dbz(dz[1]), .ovf(ov[1])
    );

    // Model state, index 0 = signed instance, 1 = unsigned instance
    logic [W-1:0] mq[2], mm[2], ma[2], mo[2], rq[2], ra[2];
    logic         mb[2], md[2], mz[2], mv[2], rv[2];
    int           tmr[2];
    int           errors = 0;
    int           checks = 0;
    bit           started = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, want);
        end
    endtask

    function automatic logic [W-1:0] b2w(input logic b);
        return {{(W-1){1'b0}}, b};
    endfunction

    // Reference: results come from integer / and %, delivered WIDTH+1 edges after RUN
    task automatic model_edge();
        int dv, dr, qv, rm;
        for (int i = 0; i < 2; i++) begin
            bit s;
            s = (i == 0);
            if (!rst_n) begin
                mq[i] = '0; mm[i] = '0; ma[i] = '0; mo[i] = '0;
                mb[i] = 1'b0; md[i] = 1'b0; mz[i] = 1'b0; mv[i] = 1'b0; tmr[i] = 0;
            end else if (tmr[i] > 0) begin
                tmr[i]--;
                if (tmr[i] == 0) begin
                    mq[i] = rq[i]; ma[i] = ra[i]; mv[i] = rv[i];
                    mb[i] = 1'b0; md[i] = 1'b1;
                end
            end else begin
                case (enable)
                    3'd1: begin ma[i] = '0; md[i] = 1'b0; mz[i] = 1'b0; mv[i] = 1'b0; end
                    3'd2: mq[i] = inbus;
                    3'd3: mm[i] = inbus;
                    3'd5: mo[i] = ma[i];
                    3'd6: mo[i] = mq[i];
                    3'd4: begin
                        if (mm[i] == '0) begin
                            ma[i] = mq[i]; mq[i] = {W{1'b1}};
                            mz[i] = 1'b1; md[i] = 1'b1; mv[i] = 1'b0;
                        end else begin
                            dv = s ? int'($signed(mq[i])) : int'(mq[i]);
                            dr = s ? int'($signed(mm[i])) : int'(mm[i]);
                            qv = dv / dr;
                            rm = dv % dr;
                            rq[i] = qv[W-1:0];
                            ra[i] = rm[W-1:0];
                            rv[i] = s && (qv == (1 << (W-1)));
                            if (s && mm[i][W-1]) mm[i] = ~mm[i] + W'(1);
                            mb[i] = 1'b1; md[i] = 1'b0; mz[i] = 1'b0; mv[i] = 1'b0;
                            tmr[i] = W + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("outbus[%0d]", i), ob[i], mo[i]);
                    chk($sformatf("busy[%0d]", i), b2w(bz[i]), b2w(mb[i]));
                    chk($sformatf("done[%0d]", i), b2w(dn[i]), b2w(md[i]));
                    chk($sformatf("dbz[%0d]", i), b2w(dz[i]), b2w(mz[i]));
                    chk($sformatf("ovf[%0d]", i), b2w(ov[i]), b2w(mv[i]));
                end
            end
        end
    end

    task automatic cmd(input logic [2:0] op, input logic [W-1:0] d);
        enable = op;
        inbus  = d;
        @(posedge clk);
        model_edge();
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic divide(input logic [W-1:0] q, input logic [W-1:0] m);
        cmd(3'd2, q);
        cmd(3'd3, m);
        cmd(3'd4, '0);
        repeat (W + 1) cmd(3'd0, '0);
    endtask

    task automatic read_chk(input string tag, input logic [W-1:0] q0, input logic [W-1:0] a0,
                            input logic [W-1:0] q1, input logic [W-1:0] a1);
        cmd(3'd6, '0);
        chk({tag, " Q signed"}, ob[0], q0);
        chk({tag, " Q unsigned"}, ob[1], q1);
        cmd(3'd5, '0);
        chk({tag, " A signed"}, ob[0], a0);
        chk({tag, " A unsigned"}, ob[1], a1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [2:0]   op;
        rst_n = 1'b0; enable = 3'd0; inbus = '0;
        @(negedge clk);
        cmd(3'd0, '0);
        cmd(3'd0, '0);
        chk("reset outbus", ob[0], 8'h00);
        chk("reset busy", b2w(bz[1]), 8'h00);
        rst_n = 1'b1;

        divide(8'h64, 8'h07);
        chk("100/7 done", b2w(dn[0]), 8'h01);
        read_chk("100/7", 8'h0E, 8'h02, 8'h0E, 8'h02);
        divide(8'h9C, 8'h07);
        read_chk("9C/07", 8'hF2, 8'hFE, 8'h16, 8'h02);
        divide(8'h64, 8'hF9);
        read_chk("64/F9", 8'hF2, 8'h02, 8'h00, 8'h64);

        cmd(3'd2, 8'h55);
        cmd(3'd3, 8'h00);
        cmd(3'd4, '0);
        chk("dbz flag", b2w(dz[0]), 8'h01);
        chk("dbz done", b2w(dn[1]), 8'h01);
        chk("dbz busy", b2w(bz[0]), 8'h00);
        read_chk("55/00", 8'hFF, 8'h55, 8'hFF, 8'h55);

        divide(8'h80, 8'hFF);
        chk("ovf signed", b2w(ov[0]), 8'h01);
        chk("ovf unsigned", b2w(ov[1]), 8'h00);
        read_chk("80/FF", 8'h80, 8'h00, 8'h00, 8'h80);

        // Commands issued mid-division must be ignored
        cmd(3'd2, 8'h64);
        cmd(3'd3, 8'h07);
        cmd(3'd4, '0);
        cmd(3'd3, 8'h01);
        cmd(3'd2, 8'h00);
        cmd(3'd6, '0);
        chk("busy store ignored s", ob[0], 8'h00);
        chk("busy store ignored u", ob[1], 8'h80);
        repeat (W - 2) cmd(3'd0, '0);
        read_chk("protected 100/7", 8'h0E, 8'h02, 8'h0E, 8'h02);

        cmd(3'd2, 8'h64);
        cmd(3'd3, 8'h07);
        cmd(3'd4, '0);
        repeat (3) cmd(3'd0, '0);
        rst_n = 1'b0;
        cmd(3'd0, '0);
        rst_n = 1'b1;
        chk("midreset outbus", ob[1], 8'h00);
        chk("midreset busy", b2w(bz[0]), 8'h00);
        chk("midreset done", b2w(dn[0]), 8'h00);
        cmd(3'd1, '0);
        divide(8'hFF, 8'h10);
        read_chk("FF/10", 8'h00, 8'hFF, 8'h0F, 8'h0F);

        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: d = 8'h00;
                    1: d = 8'h80;
                    2: d = 8'hFF;
                    default: d = 8'h01;
                endcase
            end else begin
                d = 8'($urandom);
            end
            cmd(op, d);
        end
        rst_n = 1'b1;
        repeat (W + 2) cmd(3'd0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
